// File: rtl/simon_pkg.sv
// Shared arrow codes, FSM state encoding and the arrow-validity helper for the
// Simon Says sequence checker (optional timeout feature: SEQ_CHECK_TIMEOUT_EN).
package simon_pkg;

  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_DOWN  = 3'b001;
  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_RIGHT = 3'b011;
  localparam logic [2:0] DIR_NONE  = 3'b111;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_ARM  = 3'b001;
  localparam logic [2:0] S_WAIT = 3'b010;
  localparam logic [2:0] S_PASS = 3'b011;
  localparam logic [2:0] S_FAIL = 3'b100;

  // Only the four arrow codes have a clear MSB; 100/101/110 are never arrows.
  function automatic logic is_arrow(input logic [2:0] code);
    return (code[2] == 1'b0);
  endfunction

endpackage

// File: rtl/sequence_checker_press_detect.sv
// Press detector: a press is an arrow code arriving after a released (111) cycle.
// Used by sequence_checker (optional timeout feature: SEQ_CHECK_TIMEOUT_EN).
module press_detect
  import simon_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] direction_in,
  output logic       press,
  output logic [2:0] press_dir
);

  logic [2:0] dir_prev_q;

  // Previous arrow code, tracked in every state so releases are never missed.
  always_ff @(posedge clock) begin
    if (reset) begin
      dir_prev_q <= DIR_NONE;
    end else begin
      dir_prev_q <= direction_in;
    end
  end

  assign press     = is_arrow(direction_in) && (dir_prev_q == DIR_NONE);
  assign press_dir = direction_in;

endmodule

// File: rtl/sequence_checker.sv
// Checks player presses against the stored sequence and reports step/round results.
// Optional inter-press timeout is built only when SEQ_CHECK_TIMEOUT_EN is defined.
module sequence_checker
  import simon_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TO_W           = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   round_len,
  input  logic [2:0]        direction_in,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [2:0]        exp_dir,
  output logic              busy,
  output logic              step_ok,
  output logic              round_pass,
  output logic              round_fail,
  output logic              fail_timeout,
  output logic [ADDR_W:0]   progress
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   prog_q, prog_d;
  logic              step_q, step_d;
  logic              pass_q, fail_q, fto_q, fto_d, busy_q;
  logic              press_s, restart_s, timeout_s;
  logic [2:0]        press_dir_s;

  press_detect u_press_detect (
    .clock        (clock),
    .reset        (reset),
    .direction_in (direction_in),
    .press        (press_s),
    .press_dir    (press_dir_s)
  );

  assign restart_s = start && ((state_q == S_IDLE) || (state_q == S_WAIT));

  // Next-state logic; a start in WAIT restarts the round and masks any press.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    prog_d  = prog_q;
    step_d  = 1'b0;
    fto_d   = 1'b0;
    if (restart_s) begin
      len_d   = (round_len > MAX_LEN) ? MAX_LEN : round_len;
      idx_d   = {ADDR_W{1'b0}};
      prog_d  = {LEN_W{1'b0}};
      state_d = S_ARM;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ARM:  state_d = (len_q == {LEN_W{1'b0}}) ? S_PASS : S_WAIT;
        S_WAIT: begin
          if (press_s) begin
            if (press_dir_s == exp_dir) begin
              step_d = 1'b1;
              prog_d = prog_q + LEN_W'(1);
              if ({1'b0, idx_q} == (len_q - LEN_W'(1))) begin
                state_d = S_PASS;
              end else begin
                idx_d = idx_q + ADDR_W'(1);
              end
            end else begin
              state_d = S_FAIL;
            end
          end else if (timeout_s) begin
            state_d = S_FAIL;
            fto_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_PASS:  state_d = S_IDLE;
        S_FAIL:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and Moore output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= {LEN_W{1'b0}};
      idx_q   <= {ADDR_W{1'b0}};
      prog_q  <= {LEN_W{1'b0}};
      step_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fto_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      prog_q  <= prog_d;
      step_q  <= step_d;
      pass_q  <= (state_d == S_PASS);
      fail_q  <= (state_d == S_FAIL);
      fto_q   <= fto_d;
      busy_q  <= (state_d == S_ARM) || (state_d == S_WAIT);
    end
  end

`ifdef SEQ_CHECK_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;

  assign timeout_s = (state_q == S_WAIT) && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-press timer: restarts on ARM entry and on every correct press.
  always_comb begin
    if ((state_d == S_ARM) || step_d) begin
      to_d = {TO_W{1'b0}};
    end else if (state_q == S_WAIT) begin
      to_d = to_q + TO_W'(1);
    end else begin
      to_d = to_q;
    end
  end

  // Timer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_q <= {TO_W{1'b0}};
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_cfg_s;
  assign timeout_s    = 1'b0;
  assign unused_cfg_s = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
`endif

  assign exp_addr     = idx_q;
  assign progress     = prog_q;
  assign step_ok      = step_q;
  assign round_pass   = pass_q;
  assign round_fail   = fail_q;
  assign fail_timeout = fto_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: vector table, directed corners and
// randomized rounds scored by a round-level model (timeout cases need SEQ_CHECK_TIMEOUT_EN).
module tb_sequence_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] round_len = 6'd0;
  logic [2:0] direction_in = 3'b111;
  logic [4:0] exp_addr;
  logic [2:0] exp_dir;
  logic       busy, step_ok, round_pass, round_fail, fail_timeout;
  logic [5:0] progress;

  logic [2:0] rom [32];
  int checks = 0;
  int errors = 0;
  int n_step, n_pass, n_fail;

  sequence_checker #(.ADDR_W(5), .TIMEOUT_CYCLES(10), .TO_W(26)) dut (
    .clock(clock), .reset(reset), .start(start), .round_len(round_len),
    .direction_in(direction_in), .exp_addr(exp_addr), .exp_dir(exp_dir),
    .busy(busy), .step_ok(step_ok), .round_pass(round_pass), .round_fail(round_fail),
    .fail_timeout(fail_timeout), .progress(progress)
  );

  always #5 clock = ~clock;

  // Synchronous sequence ROM with one cycle of read latency.
  always @(posedge clock) exp_dir <= rom[exp_addr];

  typedef struct {
    logic       st;
    logic [5:0] rl;
    logic [2:0] dir;
    logic       e_step, e_pass, e_fail, e_fto, e_busy;
    logic [5:0] e_prog;
    logic [4:0] e_addr;
  } vec_t;
  vec_t vt [15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (step_ok) n_step++;
    if (round_pass) n_pass++;
    if (round_fail) n_fail++;
  endtask

  task automatic drive(input logic st, input logic [2:0] d);
    start = st;
    direction_in = d;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_counts();
    n_step = 0; n_pass = 0; n_fail = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, eff, exp_ok, hold;
    logic wrong;
    logic [2:0] d;

    for (int i = 0; i < 32; i++) rom[i] = 3'b000;
    clear_counts();
    tick(); tick();
    check("reset_outputs", {busy, step_ok, round_pass, round_fail, fail_timeout, progress, exp_addr}, 0);
    reset = 1'b0;
    tick();

    // Scenario table: full pass of {001,010,011} then a wrong second arrow.
    rom[0] = 3'b001; rom[1] = 3'b010; rom[2] = 3'b011;
    vt[0]  = '{1'b1, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 5'd0};
    vt[1]  = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 5'd0};
    vt[2]  = '{1'b0, 6'd3, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1};
    vt[3]  = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1};
    vt[4]  = '{1'b0, 6'd3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd2};
    vt[5]  = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd2};
    vt[6]  = '{1'b0, 6'd3, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 5'd2};
    vt[7]  = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 5'd2};
    vt[8]  = '{1'b1, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 5'd0};
    vt[9]  = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 5'd0};
    vt[10] = '{1'b0, 6'd3, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1};
    vt[11] = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1};
    vt[12] = '{1'b0, 6'd3, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 5'd1};
    vt[13] = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 5'd1};
    vt[14] = '{1'b0, 6'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 5'd1};
    for (int v = 0; v < 15; v++) begin
      round_len = vt[v].rl;
      drive(vt[v].st, vt[v].dir);
      check($sformatf("vec%0d_step_ok", v), step_ok, vt[v].e_step);
      check($sformatf("vec%0d_round_pass", v), round_pass, vt[v].e_pass);
      check($sformatf("vec%0d_round_fail", v), round_fail, vt[v].e_fail);
      check($sformatf("vec%0d_fail_timeout", v), fail_timeout, vt[v].e_fto);
      check($sformatf("vec%0d_busy", v), busy, vt[v].e_busy);
      check($sformatf("vec%0d_progress", v), progress, vt[v].e_prog);
      check($sformatf("vec%0d_exp_addr", v), exp_addr, vt[v].e_addr);
    end

    // Held arrow across start/ARM, then a direct change: neither is a press.
    rom[0] = 3'b010; rom[1] = 3'b011; rom[2] = 3'b001;
    round_len = 6'd3;
    drive(1'b0, 3'b010);
    drive(1'b1, 3'b010);
    drive(1'b0, 3'b010);
    clear_counts();
    drive(1'b0, 3'b010);
    drive(1'b0, 3'b011);
    check("noRelease_step", n_step, 0);
    check("noRelease_fail", n_fail, 0);
    check("noRelease_busy", busy, 1);
    drive(1'b0, 3'b111);
    drive(1'b0, 3'b010);
    check("afterRelease_step_ok", step_ok, 1);
    check("afterRelease_progress", progress, 1);

    // Reset in WAIT clears everything with no pulse.
    reset = 1'b1;
    drive(1'b0, 3'b111);
    check("midReset_outputs", {busy, step_ok, round_pass, round_fail, fail_timeout, progress, exp_addr}, 0);
    reset = 1'b0;
    drive(1'b0, 3'b111);

    // Zero-length round passes two cycles after start.
    round_len = 6'd0;
    clear_counts();
    drive(1'b1, 3'b111);
    check("len0_busy_arm", busy, 1);
    check("len0_pass_early", round_pass, 0);
    drive(1'b0, 3'b111);
    check("len0_pass", round_pass, 1);
    check("len0_busy_pass", busy, 0);
    drive(1'b0, 3'b111);
    check("len0_pass_count", n_pass, 1);

    // Oversized round clamps to the 32-entry memory.
    for (int i = 0; i < 32; i++) rom[i] = 3'($urandom_range(0, 3));
    round_len = 6'd40;
    clear_counts();
    drive(1'b1, 3'b111);
    drive(1'b0, 3'b111);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, rom[i]);
      drive(1'b0, 3'b111);
    end
    drive(1'b0, 3'b111);
    check("len40_steps", n_step, 32);
    check("len40_pass", n_pass, 1);
    check("len40_fail", n_fail, 0);
    check("len40_progress", progress, 32);
    check("len40_busy", busy, 0);

    // Restart after two correct presses; the press coinciding with start is ignored.
    rom[0] = 3'b001; rom[1] = 3'b010; rom[2] = 3'b011;
    round_len = 6'd3;
    clear_counts();
    drive(1'b1, 3'b111);
    drive(1'b0, 3'b111);
    drive(1'b0, 3'b001); drive(1'b0, 3'b111);
    drive(1'b0, 3'b010); drive(1'b0, 3'b111);
    drive(1'b1, 3'b011);
    check("restart_progress", progress, 0);
    check("restart_exp_addr", exp_addr, 0);
    check("restart_busy", busy, 1);
    check("restart_step_ok", step_ok, 0);
    drive(1'b0, 3'b011);
    drive(1'b0, 3'b111);
    drive(1'b0, 3'b001);
    check("restart_first_step", step_ok, 1);
    drive(1'b0, 3'b111); drive(1'b0, 3'b010);
    drive(1'b0, 3'b111); drive(1'b0, 3'b011);
    drive(1'b0, 3'b111); drive(1'b0, 3'b111);
    check("restart_pass", n_pass, 1);
    check("restart_fail", n_fail, 0);
    check("restart_steps", n_step, 5);

`ifdef SEQ_CHECK_TIMEOUT_EN
    // Timeout fires on the tenth WAIT cycle with no press.
    clear_counts();
    drive(1'b1, 3'b111);
    for (int t = 1; t <= 10; t++) drive(1'b0, 3'b111);
    check("to_no_early_fail", n_fail, 0);
    drive(1'b0, 3'b111);
    check("to_round_fail", round_fail, 1);
    check("to_fail_timeout", fail_timeout, 1);
    drive(1'b0, 3'b111);
    check("to_fto_cleared", fail_timeout, 0);

    // A correct press in the expiry cycle beats the timeout.
    clear_counts();
    drive(1'b1, 3'b111);
    for (int t = 1; t <= 10; t++) drive(1'b0, 3'b111);
    drive(1'b0, rom[0]);
    check("to_press_wins_step", step_ok, 1);
    check("to_press_wins_fail", round_fail, 0);
    drive(1'b0, 3'b111);
    check("to_press_wins_nofail", n_fail, 0);
    reset = 1'b1;
    drive(1'b0, 3'b111);
    reset = 1'b0;
    drive(1'b0, 3'b111);
`endif

    // Randomized rounds scored by counting expected outcomes per round.
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 40);
      eff = (len > 32) ? 32 : len;
      for (int i = 0; i < 32; i++) rom[i] = 3'($urandom_range(0, 3));
      round_len = 6'(len);
      clear_counts();
      drive(1'b1, 3'b111);
      drive(1'b0, 3'b111);
      exp_ok = 0;
      wrong = 1'b0;
      for (int k = 0; k < eff && !wrong; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          d = 3'((int'(rom[k]) + $urandom_range(1, 3)) % 4);
          wrong = 1'b1;
        end else begin
          d = rom[k];
          exp_ok++;
        end
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) drive(1'b0, d);
        drive(1'b0, 3'b111);
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 3'($urandom_range(4, 6)));
          drive(1'b0, 3'b111);
        end
      end
      drive(1'b0, 3'b111);
      drive(1'b0, 3'b111);
      check($sformatf("rnd%0d_steps", r), n_step, exp_ok);
      check($sformatf("rnd%0d_pass", r), n_pass, wrong ? 0 : 1);
      check($sformatf("rnd%0d_fail", r), n_fail, wrong ? 1 : 0);
      check($sformatf("rnd%0d_progress", r), progress, exp_ok);
      check($sformatf("rnd%0d_idle", r), busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
